// File: rtl/ps2_kbd_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ps2_kbd_ctrl_pkg
//  Shared definitions for the PS/2 keyboard controller:
//   - prefix byte values (E0 = extended, F0 = break)
//   - decoder FSM state encoding (2 bits)
//   - key event word layout, 10 bits: {ext, brk, code}
//  No ports; imported by ps2_kbd_ctrl and ps2_evt_fifo.
// ----------------------------------------------------------------------------
package ps2_kbd_ctrl_pkg;

    localparam logic [7:0] PS2_CODE_EXT = 8'hE0;
    localparam logic [7:0] PS2_CODE_BRK = 8'hF0;

    localparam int EVT_CODE_W = 8;
    localparam int EVT_W      = EVT_CODE_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    typedef struct packed {
        logic                  ext;
        logic                  brk;
        logic [EVT_CODE_W-1:0] code;
    } key_evt_t;

endpackage

// File: rtl/ps2_kbd_ctrl_evt_fifo.sv
// ----------------------------------------------------------------------------
// ps2_evt_fifo
//  Synchronous FIFO for decoded key events, depth 2**AW, width W.
//  A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
//  if a pop happens in the same cycle. The read port shows the head entry
//  (all zeros while empty).
//  Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push/pop   write / read request
//   wr_data    word to write
//   rd_data    FIFO head
//   full/empty current occupancy flags
//   full_nxt   occupancy flag the FIFO will have after this cycle
// ----------------------------------------------------------------------------
module ps2_evt_fifo
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int W  = EVT_W,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty,
    output logic         full_nxt
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    assign full_nxt = (count_d == CW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the read port is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_kbd_ctrl
//  Turns the byte stream of a PS/2 receive core into key events. E0/F0
//  prefixes are folded into one {ext, brk, code} event per key, which is
//  queued in a small FIFO and read with a valid/ready handshake.
//  Optional feature macro: PS2_KBD_TYPEMATIC_FILTER_EN
//   When defined, repeated make codes of the held key (typematic repeat) are
//   suppressed until that key is released or another key is pressed.
//  Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_rx_done_tick       rx core byte strobe, with i_rx_data
//   i_time_out           rx core frame watchdog
//   o_rx_en              rx core enable, low while the FIFO is full
//   o_key_valid/i_key_ready  event handshake
//   o_key_code/ext/break FIFO head event
//   o_seq_err            one-cycle pulse when a prefix sequence is aborted
//   o_overrun            sticky event-dropped flag, cleared by i_clr_err
// ----------------------------------------------------------------------------
module ps2_kbd_ctrl
    import ps2_kbd_ctrl_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 200000,
    parameter int FIFO_AW        = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx_done_tick,
    input  logic [7:0] i_rx_data,
    input  logic       i_time_out,
    output logic       o_rx_en,
    output logic       o_key_valid,
    input  logic       i_key_ready,
    output logic [7:0] o_key_code,
    output logic       o_key_ext,
    output logic       o_key_break,
    output logic       o_seq_err,
    output logic       o_overrun,
    input  logic       i_clr_err
);

    localparam int TW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);

    dec_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          seq_err_q, seq_err_d;
    logic          overrun_q, overrun_d;
    logic          rx_en_q;
    logic          emit;
    logic          evt_ext;
    logic          evt_brk;
    logic          push;
    logic          pop;
    logic          drop;
    key_evt_t      push_evt;
    key_evt_t      head_evt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_full_nxt;

    // Decoder: bytes advance the FSM; while a prefix is pending the timer runs
    // and either the timer or the rx watchdog abandons the sequence. A byte
    // arriving in the same cycle as the watchdog takes precedence.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        seq_err_d = 1'b0;
        emit      = 1'b0;
        evt_ext   = 1'b0;
        evt_brk   = 1'b0;
        if (i_rx_done_tick) begin
            timer_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_data == PS2_CODE_EXT)      state_d = ST_EXT;
                    else if (i_rx_data == PS2_CODE_BRK) state_d = ST_BRK;
                    else                                emit = 1'b1;
                end
                ST_EXT: begin
                    if (i_rx_data == PS2_CODE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (i_rx_data != PS2_CODE_EXT) begin
                        emit    = 1'b1;
                        evt_ext = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit    = 1'b1;
                    evt_brk = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    emit    = 1'b1;
                    evt_ext = 1'b1;
                    evt_brk = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (i_time_out || timer_q == TIMER_LAST) begin
                state_d   = ST_IDLE;
                timer_d   = '0;
                seq_err_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    assign push_evt = {evt_ext, evt_brk, i_rx_data};

`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
    logic       last_vld_q, last_vld_d;
    logic       last_ext_q, last_ext_d;
    logic [7:0] last_code_q, last_code_d;
    logic       last_match;

    assign last_match = last_vld_q && (last_ext_q == evt_ext) && (last_code_q == i_rx_data);

    // Suppress a make identical to the last one; a matching break re-arms it.
    always_comb begin
        last_vld_d  = last_vld_q;
        last_ext_d  = last_ext_q;
        last_code_d = last_code_q;
        push        = emit;
        if (emit) begin
            if (!evt_brk) begin
                if (last_match) begin
                    push = 1'b0;
                end else begin
                    last_vld_d  = 1'b1;
                    last_ext_d  = evt_ext;
                    last_code_d = i_rx_data;
                end
            end else if (last_match) begin
                last_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_vld_q  <= 1'b0;
            last_ext_q  <= 1'b0;
            last_code_q <= '0;
        end else begin
            last_vld_q  <= last_vld_d;
            last_ext_q  <= last_ext_d;
            last_code_q <= last_code_d;
        end
    end
`else
    assign push = emit;
`endif

    assign pop  = ~fifo_empty & i_key_ready;
    assign drop = push & fifo_full & ~pop;

    // An overrun in the clearing cycle must survive the clear.
    always_comb begin
        overrun_d = i_clr_err ? 1'b0 : overrun_q;
        if (drop) overrun_d = 1'b1;
    end

    // rx enable follows the occupancy the FIFO will have next cycle, so it
    // drops in the same cycle the FIFO becomes full.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            seq_err_q <= 1'b0;
            overrun_q <= 1'b0;
            rx_en_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            seq_err_q <= seq_err_d;
            overrun_q <= overrun_d;
            rx_en_q   <= ~fifo_full_nxt;
        end
    end

    ps2_evt_fifo #(
        .W  (EVT_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (i_clk),
        .rst      (i_reset),
        .push     (push),
        .pop      (pop),
        .wr_data  (push_evt),
        .rd_data  (head_evt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .full_nxt (fifo_full_nxt)
    );

    assign o_rx_en     = rx_en_q;
    assign o_key_valid = ~fifo_empty;
    assign o_key_code  = head_evt.code;
    assign o_key_ext   = head_evt.ext;
    assign o_key_break = head_evt.brk;
    assign o_seq_err   = seq_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_kbd_ctrl
//  Self-checking bench for ps2_kbd_ctrl. A queue-based model of the key event
//  stream is checked against the DUT on every cycle, alongside directed
//  scenarios with literal expectations and a randomized phase.
//  Honours PS2_KBD_TYPEMATIC_FILTER_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_ps2_kbd_ctrl;

    localparam int TB_PT = 24;
    localparam int TB_AW = 2;
    localparam int DEPTH = 1 << TB_AW;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic [7:0] data;
    logic       to;
    logic       ready;
    logic       clr;
    logic       rx_en;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       seq_err;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ps2_kbd_ctrl #(
        .PREFIX_TIMEOUT (TB_PT),
        .FIFO_AW        (TB_AW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_rx_done_tick (done),
        .i_rx_data      (data),
        .i_time_out     (to),
        .o_rx_en        (rx_en),
        .o_key_valid    (key_valid),
        .i_key_ready    (ready),
        .o_key_code     (key_code),
        .o_key_ext      (key_ext),
        .o_key_break    (key_break),
        .o_seq_err      (seq_err),
        .o_overrun      (overrun),
        .i_clr_err      (clr)
    );

    // Reference model: pending-prefix flags, a wait counter and an event queue.
    logic [9:0] m_q[$];
    bit         m_pend, m_ext, m_brk, m_err, m_ovr;
    int         m_wait;
    bit         m_lv, m_le;
    logic [7:0] m_lc;

    function automatic void m_push(logic [7:0] code, bit ext, bit brk);
        bit keep = 1'b1;
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
        bit same = m_lv && (m_le == ext) && (m_lc == code);
        if (!brk) begin
            if (same) keep = 1'b0;
            else begin
                m_lv = 1'b1;
                m_le = ext;
                m_lc = code;
            end
        end else if (same) begin
            m_lv = 1'b0;
        end
`endif
        if (keep) begin
            if (m_q.size() < DEPTH) m_q.push_back({ext, brk, code});
            else m_ovr = 1'b1;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_pend = 0; m_ext = 0; m_brk = 0; m_err = 0; m_ovr = 0; m_wait = 0;
            m_lv = 0; m_le = 0; m_lc = 8'h00;
        end else begin
            m_err = 1'b0;
            if (clr) m_ovr = 1'b0;
            if (m_q.size() > 0 && ready) void'(m_q.pop_front());
            if (done) begin
                m_wait = 0;
                if (m_brk) begin
                    m_push(data, m_ext, 1'b1);
                    m_pend = 0; m_ext = 0; m_brk = 0;
                end else if (data == 8'hE0) begin
                    m_pend = 1; m_ext = 1;
                end else if (data == 8'hF0) begin
                    m_pend = 1; m_brk = 1;
                end else begin
                    m_push(data, m_ext, 1'b0);
                    m_pend = 0; m_ext = 0;
                end
            end else if (m_pend) begin
                if (to || m_wait == TB_PT - 1) begin
                    m_err = 1'b1;
                    m_pend = 0; m_ext = 0; m_brk = 0; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("valid", 32'(key_valid), 32'(m_q.size() > 0));
            checkOutput("rx_en", 32'(rx_en), 32'(m_q.size() < DEPTH));
            checkOutput("seq_err", 32'(seq_err), 32'(m_err));
            checkOutput("overrun", 32'(overrun), 32'(m_ovr));
            if (m_q.size() > 0)
                checkOutput("head", 32'({key_ext, key_break, key_code}), 32'(m_q[0]));
        end
    end

    task automatic applyStimulus(input logic d, input logic [7:0] b, input logic t);
        done = d;
        data = b;
        to   = t;
        @(posedge clk);
        #1;
        done = 1'b0;
        to   = 1'b0;
        clr  = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0);
    endtask

    task automatic drain();
        ready = 1'b1;
        repeat (DEPTH + 2) applyStimulus(1'b0, 8'h00, 1'b0);
        ready = 1'b0;
    endtask

    logic [7:0] pool [6];
    logic [7:0] t6_seq [6];
    logic [9:0] t6_got [8];
    logic [9:0] t6_exp [5];
    int         t6_n;
    int         err_cnt;
    int         exp_n;

    initial begin
        rst = 1'b1; done = 1'b0; data = 8'h00; to = 1'b0; ready = 1'b0; clr = 1'b0;
        pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h1C;
        pool[3] = 8'h75; pool[4] = 8'h12; pool[5] = 8'hE1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rx_en", 32'(rx_en), 32'd1);
        checkOutput("rst_valid", 32'(key_valid), 32'd0);
        checkOutput("rst_code", 32'(key_code), 32'd0);
        checkOutput("rst_ext", 32'(key_ext), 32'd0);
        checkOutput("rst_break", 32'(key_break), 32'd0);
        checkOutput("rst_seq_err", 32'(seq_err), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Plain make code, latency 1
        @(negedge clk);
        checkOutput("t1_valid_before", 32'(key_valid), 32'd0);
        sendByte(8'h1C);
        @(negedge clk);
        checkOutput("t1_valid", 32'(key_valid), 32'd1);
        checkOutput("t1_event", 32'({key_ext, key_break, key_code}), 32'h01C);
        drain();

        // Break and extended break, order preserved
        sendByte(8'hF0); sendByte(8'h1C);
        sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
        @(negedge clk);
        checkOutput("t2_first", 32'({key_ext, key_break, key_code}), 32'h11C);
        ready = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        ready = 1'b0;
        @(negedge clk);
        checkOutput("t2_second", 32'({key_ext, key_break, key_code}), 32'h375);
        drain();

        // Prefix timer expiry
        sendByte(8'hE0);
        err_cnt = 0;
        repeat (TB_PT + 3) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            @(negedge clk);
            err_cnt += int'(seq_err);
        end
        checkOutput("t3_err_pulses", 32'(err_cnt), 32'd1);
        sendByte(8'h1C);
        @(negedge clk);
        checkOutput("t3_after", 32'({key_ext, key_break, key_code}), 32'h01C);
        drain();

        // Overflow: 5 events into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            sendByte(8'(i));
            if (i == 4) begin
                @(negedge clk);
                checkOutput("t4_rx_en_low", 32'(rx_en), 32'd0);
            end
        end
        @(negedge clk);
        checkOutput("t4_overrun", 32'(overrun), 32'd1);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            checkOutput("t4_drain", 32'(key_code), 32'(i));
            @(posedge clk); #1;
            @(negedge clk);
        end
        ready = 1'b0;
        checkOutput("t4_empty", 32'(key_valid), 32'd0);
        clr = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("t4_cleared", 32'(overrun), 32'd0);

        // Watchdog abort, and tick winning over a simultaneous watchdog
        sendByte(8'hE0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("t5_err", 32'(seq_err), 32'd1);
        checkOutput("t5_no_event", 32'(key_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("t5_err_one_cycle", 32'(seq_err), 32'd0);
        sendByte(8'hE0);
        applyStimulus(1'b1, 8'h1C, 1'b1);
        @(negedge clk);
        checkOutput("t5_tick_wins_err", 32'(seq_err), 32'd0);
        checkOutput("t5_tick_wins_evt", 32'({key_ext, key_break, key_code}), 32'h21C);
        drain();

        // Mid-run reset, then typematic sequence
        sendByte(8'hE0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_valid", 32'(key_valid), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        t6_seq[0] = 8'h1C; t6_seq[1] = 8'h1C; t6_seq[2] = 8'h1C;
        t6_seq[3] = 8'hF0; t6_seq[4] = 8'h1C; t6_seq[5] = 8'h1C;
`ifdef PS2_KBD_TYPEMATIC_FILTER_EN
        exp_n = 3;
        t6_exp[0] = 10'h01C; t6_exp[1] = 10'h11C; t6_exp[2] = 10'h01C;
        t6_exp[3] = 10'h000; t6_exp[4] = 10'h000;
`else
        exp_n = 5;
        t6_exp[0] = 10'h01C; t6_exp[1] = 10'h01C; t6_exp[2] = 10'h01C;
        t6_exp[3] = 10'h11C; t6_exp[4] = 10'h01C;
`endif
        t6_n = 0;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sendByte(t6_seq[i]);
            @(negedge clk);
            if (key_valid && t6_n < 8) begin
                t6_got[t6_n] = {key_ext, key_break, key_code};
                t6_n++;
            end
        end
        ready = 1'b0;
        checkOutput("t6_count", 32'(t6_n), 32'(exp_n));
        for (int i = 0; i < exp_n && i < t6_n; i++)
            checkOutput("t6_event", 32'(t6_got[i]), 32'(t6_exp[i]));
        drain();

        // Randomized traffic: busy phase, then sparse phase to hit timeouts
        for (int i = 0; i < 3000; i++) begin
            if (i == 700) begin
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
            end
            ready = ($urandom_range(0, 99) < 60);
            clr   = ($urandom_range(0, 99) < 3);
            applyStimulus(($urandom_range(0, 99) < ((i < 1500) ? 40 : 3)),
                          pool[$urandom_range(0, 5)],
                          ($urandom_range(0, 99) < 4));
        end
        ready = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
